// File: rtl/rsa_mont_engine_if.sv
// Handshake bundle between the RSA core and the Montgomery engine.
// The core drives operands/start; the engine returns result/finished/busy.
interface rsa_mont_engine_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_mode, i_a, i_b, i_n,
    input  o_result, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_mode, i_a, i_b, i_n,
    output o_result, o_finished, o_busy
  );
endinterface

// File: rtl/rsa_mont_engine.sv
// Bit-serial Montgomery engine: MUL (a*b*2^-W mod n) or TRANS (a*2^W mod n).
// One iteration per clock, WIDTH iterations, then a final conditional subtract.
module rsa_mont_engine #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rsa_mont_engine_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] result_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             fin_q;

  logic [AW-1:0]    n_ext;
  logic [AW-1:0]    b_ext;
  logic [AW-1:0]    mul_t;
  logic [AW-1:0]    mul_u;
  logic [AW-1:0]    tr_t;
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] fix_d;
  logic             a_bit;
  logic             last;
  logic             ge_n;

  assign n_ext = {2'b00, n_q};
  assign b_ext = {2'b00, b_q};
  assign a_bit = a_q[cnt_q[IW-1:0]];
  assign last  = (cnt_q == CW'(WIDTH - 1));
  assign ge_n  = (acc_q >= n_ext);

  // Low WIDTH bits of acc-n equal the low bits of the full-width difference.
  assign fix_d = acc_q[WIDTH-1:0] - (ge_n ? n_q : '0);

  always_comb begin
    mul_t = acc_q + (a_bit ? b_ext : '0);
    mul_u = mul_t[0] ? (mul_t + n_ext) : mul_t;
    tr_t  = {acc_q[AW-2:0], 1'b0};
    if (mode_q) begin
      acc_d = (tr_t >= n_ext) ? (tr_t - n_ext) : tr_t;
    end else begin
      acc_d = mul_u >> 1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = CALC;
      CALC:    if (last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            mode_q <= bus.i_mode;
            a_q    <= bus.i_a;
            b_q    <= bus.i_b;
            n_q    <= bus.i_n;
            acc_q  <= bus.i_mode ? {2'b00, bus.i_a} : '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          result_q <= fix_d;
          fin_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_result   = result_q;
  assign bus.o_finished = fin_q;
  assign bus.o_busy     = (state_q == CALC) || (state_q == FIX);
endmodule

// File: tb/tb_rsa_mont_engine.sv
// Scoreboard bench for rsa_mont_engine at WIDTH=8 (directed) and WIDTH=256.
// Drivers push expected results; per-instance monitors pop on o_finished.
module tb_rsa_mont_engine;
  localparam int W8 = 8;
  localparam int WB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] res;
    int unsigned  start;
  } exp_t;

  exp_t q8[$];
  exp_t qb[$];
  bit   p8 = 1'b0;
  bit   pb = 1'b0;

  rsa_mont_engine_if #(.WIDTH(W8)) b8 ();
  rsa_mont_engine_if #(.WIDTH(WB)) bb ();

  rsa_mont_engine #(.WIDTH(W8)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b8)
  );

  rsa_mont_engine #(.WIDTH(WB)) dutb (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bb)
  );

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (p8) begin
      checks++;
      if (b8.o_finished !== 1'b0) begin
        errors++;
        $display("FAIL pulse8: finished=%b required 0", b8.o_finished);
      end
    end
    if (b8.o_finished === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra8: unexpected finished, result %0h",
                 b8.o_result);
      end else begin
        e = q8.pop_front();
        checks += 2;
        if (256'(b8.o_result) !== e.res) begin
          errors++;
          $display("FAIL res8: got %0h required %0h", b8.o_result, e.res);
        end
        if (cyc + 1 - e.start != W8 + 2) begin
          errors++;
          $display("FAIL lat8: got %0d required %0d",
                   cyc + 1 - e.start, W8 + 2);
        end
      end
    end
    p8 = (b8.o_finished === 1'b1);
  end

  always @(negedge clk) begin : monb
    exp_t e;
    if (pb) begin
      checks++;
      if (bb.o_finished !== 1'b0) begin
        errors++;
        $display("FAIL pulse256: finished=%b required 0", bb.o_finished);
      end
    end
    if (bb.o_finished === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra256: unexpected finished");
      end else begin
        e = qb.pop_front();
        checks += 2;
        if (bb.o_result !== e.res) begin
          errors++;
          $display("FAIL res256: got %0h required %0h", bb.o_result, e.res);
        end
        if (cyc + 1 - e.start != WB + 2) begin
          errors++;
          $display("FAIL lat256: got %0d required %0d",
                   cyc + 1 - e.start, WB + 2);
        end
      end
    end
    pb = (bb.o_finished === 1'b1);
  end

  task automatic wait_idle8();
    int n = 0;
    while (!(b8.o_busy === 1'b0 && b8.o_finished === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle8: timeout waiting for IDLE");
    end
  endtask

  task automatic wait_fin8();
    int n = 0;
    while (b8.o_finished !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL fin8: timeout waiting for finished");
    end
  endtask

  task automatic wait_finb();
    int n = 0;
    while (bb.o_finished !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL fin256: timeout waiting for finished");
    end
  endtask

  task automatic op8(input bit mode, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] n,
                     input logic [7:0] exp, input bit push);
    @(negedge clk);
    wait_idle8();
    b8.i_mode  = mode;
    b8.i_a     = a;
    b8.i_b     = b;
    b8.i_n     = n;
    b8.i_start = 1'b1;
    if (push) q8.push_back('{res: 256'(exp), start: cyc + 1});
    @(negedge clk);
    b8.i_start = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mmod(input logic [511:0] x,
                                        input logic [255:0] m);
    logic [511:0] r;
    r = x % {256'b0, m};
    return r[255:0];
  endfunction

  function automatic logic [255:0] mulmod(input logic [255:0] x,
                                          input logic [255:0] y,
                                          input logic [255:0] m);
    return mmod({256'b0, x} * {256'b0, y}, m);
  endfunction

  // 2^-1 mod odd n is (n+1)/2, so R^-1 is that raised to WB.
  function automatic logic [255:0] gold(input bit mode,
                                        input logic [255:0] a,
                                        input logic [255:0] b,
                                        input logic [255:0] n);
    logic [255:0] h;
    logic [255:0] ri;
    if (mode) return mmod({a, 256'b0}, n);
    h  = (n >> 1) + 256'd1;
    ri = 256'd1;
    for (int i = 0; i < WB; i++) ri = mulmod(ri, h, n);
    return mulmod(mulmod(a, b, n), ri, n);
  endfunction

  task automatic load_b(input int k);
    logic [255:0] n;
    logic [255:0] a;
    logic [255:0] b;
    bit           m;
    n = rnd256() | 256'd1;
    if (k % 3 == 0) n[255] = 1'b1;
    a = mmod({256'b0, rnd256()}, n);
    b = mmod({256'b0, rnd256()}, n);
    m = k[0];
    bb.i_mode = m;
    bb.i_a    = a;
    bb.i_b    = b;
    bb.i_n    = n;
    qb.push_back('{res: gold(m, a, b, n), start: 0});
  endtask

  initial begin
    b8.i_start = 1'b0;
    b8.i_mode  = 1'b0;
    b8.i_a     = '0;
    b8.i_b     = '0;
    b8.i_n     = '0;
    bb.i_start = 1'b0;
    bb.i_mode  = 1'b0;
    bb.i_a     = '0;
    bb.i_b     = '0;
    bb.i_n     = '0;
    repeat (3) @(negedge clk);
    chk("rst_res8", 256'(b8.o_result), 256'd0);
    chk("rst_busy8", 256'(b8.o_busy), 256'd0);
    chk("rst_fin8", 256'(b8.o_finished), 256'd0);
    chk("rst_res256", bb.o_result, 256'd0);
    chk("rst_busy256", 256'(bb.o_busy), 256'd0);
    rst = 1'b0;

    op8(1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b1);
    op8(1'b1, 8'd5, 8'hFF, 8'd13, 8'd6, 1'b1);
    op8(1'b0, 8'd254, 8'd254, 8'd255, 8'd1, 1'b1);
    op8(1'b0, 8'd0, 8'd77, 8'd255, 8'd0, 1'b1);
    op8(1'b0, 8'd1, 8'd1, 8'd13, 8'd3, 1'b1);
    op8(1'b1, 8'd1, 8'd0, 8'd13, 8'd9, 1'b1);
    op8(1'b0, 8'd12, 8'd12, 8'd13, 8'd3, 1'b1);
    op8(1'b1, 8'd3, 8'd0, 8'd251, 8'd15, 1'b1);
    op8(1'b1, 8'd200, 8'd0, 8'd255, 8'd200, 1'b1);
    op8(1'b1, 8'd128, 8'd0, 8'd129, 8'd2, 1'b1);

    // start pulses mid-CALC and in DONE are ignored
    op8(1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b1);
    repeat (2) @(negedge clk);
    b8.i_mode  = 1'b1;
    b8.i_a     = 8'd2;
    b8.i_b     = 8'd3;
    b8.i_n     = 8'd11;
    b8.i_start = 1'b1;
    @(negedge clk);
    b8.i_start = 1'b0;
    wait_fin8();
    b8.i_start = 1'b1;
    @(negedge clk);
    b8.i_start = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_busy", 256'(b8.o_busy), 256'd0);

    // reset mid-CALC
    op8(1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 256'(b8.o_busy), 256'd0);
    chk("t5_fin", 256'(b8.o_finished), 256'd0);
    chk("t5_res", 256'(b8.o_result), 256'd0);
    rst = 1'b0;
    op8(1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b1);

    // start held high across DONE->IDLE
    @(negedge clk);
    wait_idle8();
    b8.i_mode  = 1'b0;
    b8.i_a     = 8'd254;
    b8.i_b     = 8'd254;
    b8.i_n     = 8'd255;
    b8.i_start = 1'b1;
    q8.push_back('{res: 256'd1, start: cyc + 1});
    @(negedge clk);
    wait_fin8();
    b8.i_mode = 1'b1;
    b8.i_a    = 8'd5;
    b8.i_n    = 8'd13;
    q8.push_back('{res: 256'd6, start: cyc + 2});
    @(negedge clk);
    wait_fin8();
    b8.i_start = 1'b0;

    // WIDTH=256 back-to-back, both modes, model-checked
    @(negedge clk);
    load_b(0);
    qb[qb.size()-1].start = cyc + 1;
    bb.i_start = 1'b1;
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      wait_finb();
      load_b(k);
      qb[qb.size()-1].start = cyc + 2;
    end
    @(negedge clk);
    wait_finb();
    bb.i_start = 1'b0;

    repeat (5) @(negedge clk);
    chk("drain8", 256'(q8.size()), 256'd0);
    chk("drain256", 256'(qb.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
